prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 178 +++++++++++++++++
 tb/tb_prog_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: streams program words into instruction memory, then enables the CPU.
// Define LOADER_READBACK_EN to add a checksum readback pass (VERIFY and ERR states).
module prog_loader #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   n_words,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [63:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef LOADER_READBACK_EN
    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RUN, ERR} state_e;
`else
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
`endif

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ADDR_W:0]     acc_q, acc_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                load_room;
    logic                accept;

`ifdef LOADER_READBACK_EN
    logic                ren_q, ren_d;
    logic                rd_pend_q, rd_pend_d;
    logic [ADDR_W:0]     rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0]   rsum_q, rsum_d;
    logic [DATA_W-1:0]   rsum_nxt;

    assign rsum_nxt = rsum_q + rdata_ext;
`else
    logic                unused_rdata;

    assign unused_rdata = ^rdata_ext;
`endif

    assign load_room = (acc_q < n_q);
    assign accept    = (state_q == LOAD) && load_room && s_valid;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_READBACK_EN
        ren_d     = 1'b0;
        rd_pend_d = ren_q;
        rd_idx_d  = rd_idx_q;
        rsum_d    = rsum_q;
`endif
        case (state_q)
            LOAD: begin
                if (accept) begin
                    wen_d   = 1'b1;
                    addr_d  = acc_q[ADDR_W-1:0];
                    wdata_d = s_data;
                    acc_d   = acc_q + 1'b1;
                    sum_d   = sum_q + s_data;
                end
                // acc_q reaches n_q in the cycle the last write is on the bus
                if (acc_q == n_q) begin
`ifdef LOADER_READBACK_EN
                    state_d  = VERIFY;
                    ren_d    = 1'b1;
                    addr_d   = '0;
                    rd_idx_d = {{ADDR_W{1'b0}}, 1'b1};
                    rsum_d   = '0;
`else
                    state_d  = RUN;
`endif
                end
            end
`ifdef LOADER_READBACK_EN
            VERIFY: begin
                if (ren_q && (rd_idx_q < n_q)) begin
                    ren_d    = 1'b1;
                    addr_d   = rd_idx_q[ADDR_W-1:0];
                    rd_idx_d = rd_idx_q + 1'b1;
                end
                if (rd_pend_q) begin
                    rsum_d = rsum_nxt;
                    // data pending with no read issued means this is the final word
                    if (!ren_q) begin
                        state_d = (rsum_nxt == sum_q) ? RUN : ERR;
                    end
                end
            end
`endif
            default: begin
                if (start) begin
                    if (n_words == '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = LOAD;
                        n_d     = (n_words > MAX_WORDS) ? MAX_WORDS : n_words;
                        acc_d   = '0;
                        sum_d   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef LOADER_READBACK_EN
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            ren_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            rsum_q    <= '0;
        end else begin
            ren_q     <= ren_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
            rsum_q    <= rsum_d;
        end
    end

    assign ren_ext = ren_q;
    assign err     = (state_q == ERR);
    assign busy    = (state_q == LOAD) || (state_q == VERIFY);
`else
    assign ren_ext = 1'b0;
    assign err     = 1'b0;
    assign busy    = (state_q == LOAD);
`endif

    assign s_ready    = (state_q == LOAD) && load_room;
    assign wen_ext    = wen_q;
    assign wdata_ext  = wdata_q;
    assign addr_ext   = {{(64 - ADDR_W - 2){1'b0}}, addr_q, 2'b00};
    assign cpu_enable = (state_q == RUN);
    assign done       = (state_q == RUN);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; readback scenario runs when LOADER_READBACK_EN is defined.
module tb_prog_loader;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [9:0]  n_words;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata;
    logic        cpu_enable;
    logic        busy;
    logic        done;
    logic        err;

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [0:511];
    logic        corrupt = 1'b0;

    prog_loader #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .n_words    (n_words),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .addr_ext   (addr_ext),
        .wen_ext    (wen_ext),
        .ren_ext    (ren_ext),
        .wdata_ext  (wdata_ext),
        .rdata_ext  (rdata),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: write/read on the rising edge; optional corruption of 0x1 at byte addr 4.
    always @(posedge clk) begin
        if (wen_ext)
            mem[addr_ext[10:2]] <= (corrupt && addr_ext == 64'd4 && wdata_ext == 32'h1) ? 32'h3 : wdata_ext;
        if (ren_ext)
            rdata <= mem[addr_ext[10:2]];
    end

    function automatic int run_lat(input int n);
`ifdef LOADER_READBACK_EN
        return n + 2;
`else
        return 1;
`endif
    endfunction

    task automatic wait_run(input int max_cycles, output int cycles);
        cycles = 0;
        while (cpu_enable !== 1'b1 && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic apply_reset();
        arst_n = 1'b0; start = 1'b0; s_valid = 1'b0; n_words = '0; s_data = '0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({cpu_enable, done, busy, err, wen_ext, ren_ext, s_ready} !== 7'b0)
            $display("FAIL reset_flags got=%b exp=0000000", {cpu_enable, done, busy, err, wen_ext, ren_ext, s_ready});
        else passed++;
        total++;
        if ({addr_ext, wdata_ext} !== 96'd0)
            $display("FAIL reset_bus got addr=%h wdata=%h exp 0/0", addr_ext, wdata_ext);
        else passed++;
        @(negedge clk);
        total++;
        if ({cpu_enable, busy, wen_ext, s_ready} !== 4'b0)
            $display("FAIL idle_flags got=%b exp=0000", {cpu_enable, busy, wen_ext, s_ready});
        else passed++;
    endtask

    task automatic test_load3();
        logic [31:0] w [3];
        int cyc;
        w[0] = 32'h0050_0093; w[1] = 32'h0010_8113; w[2] = 32'h0000_006F;
        start = 1'b1; n_words = 10'd3; s_valid = 1'b1; s_data = w[0];
        @(negedge clk);
        total++;
        if ({s_ready, busy, wen_ext, cpu_enable} !== 4'b1100)
            $display("FAIL load3_enter got=%b exp=1100", {s_ready, busy, wen_ext, cpu_enable});
        else passed++;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({wen_ext, addr_ext, wdata_ext} !== {1'b1, 64'(4 * i), w[i]})
                $display("FAIL load3_wr%0d got wen=%b addr=%h data=%h exp 1/%h/%h",
                         i, wen_ext, addr_ext, wdata_ext, 64'(4 * i), w[i]);
            else passed++;
            if (i < 2) s_data = w[i + 1];
            else s_valid = 1'b0;
        end
        total++;
        if (s_ready !== 1'b0) $display("FAIL load3_ready_end got=%b exp=0", s_ready);
        else passed++;
        wait_run(40, cyc);
        total++;
        if (cyc !== run_lat(3)) $display("FAIL load3_run_lat got=%0d exp=%0d", cyc, run_lat(3));
        else passed++;
        total++;
        if ({cpu_enable, done, busy, wen_ext, ren_ext, s_ready, err} !== 7'b1100000)
            $display("FAIL load3_run got=%b exp=1100000", {cpu_enable, done, busy, wen_ext, ren_ext, s_ready, err});
        else passed++;
    endtask

    task automatic test_toggle();
        int cyc;
        start = 1'b1; n_words = 10'd2; s_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({cpu_enable, busy, s_ready} !== 3'b011)
            $display("FAIL tog_enter got=%b exp=011", {cpu_enable, busy, s_ready});
        else passed++;
        start = 1'b0; s_valid = 1'b1; s_data = 32'hA5A5_0001;
        @(negedge clk);
        total++;
        if ({wen_ext, addr_ext, wdata_ext} !== {1'b1, 64'd0, 32'hA5A5_0001})
            $display("FAIL tog_wr0 got wen=%b addr=%h data=%h exp 1/0/a5a50001", wen_ext, addr_ext, wdata_ext);
        else passed++;
        s_valid = 1'b0; s_data = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if ({wen_ext, s_ready} !== 2'b01)
            $display("FAIL tog_gap got wen,rdy=%b exp=01", {wen_ext, s_ready});
        else passed++;
        s_valid = 1'b1; s_data = 32'h1234_5678;
        @(negedge clk);
        total++;
        if ({wen_ext, addr_ext, wdata_ext, s_ready} !== {1'b1, 64'd4, 32'h1234_5678, 1'b0})
            $display("FAIL tog_wr1 got wen=%b addr=%h data=%h rdy=%b exp 1/4/12345678/0",
                     wen_ext, addr_ext, wdata_ext, s_ready);
        else passed++;
        s_data = 32'hFFFF_FFFF;
        wait_run(40, cyc);
        s_valid = 1'b0;
        total++;
        if (cyc !== run_lat(2)) $display("FAIL tog_run_lat got=%0d exp=%0d", cyc, run_lat(2));
        else passed++;
        total++;
        if (wen_ext !== 1'b0) $display("FAIL tog_run_wen got=%b exp=0", wen_ext);
        else passed++;
    endtask

    task automatic test_start_ignored();
        int cyc;
        start = 1'b1; n_words = 10'd3; s_valid = 1'b1; s_data = 32'h0000_0AA0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({wen_ext, addr_ext} !== {1'b1, 64'd0})
            $display("FAIL ign_wr0 got wen=%b addr=%h exp 1/0", wen_ext, addr_ext);
        else passed++;
        start = 1'b1; n_words = 10'd1; s_data = 32'h0000_0AA1;
        @(negedge clk);
        total++;
        if ({wen_ext, addr_ext, wdata_ext, busy} !== {1'b1, 64'd4, 32'h0000_0AA1, 1'b1})
            $display("FAIL ign_wr1 got wen=%b addr=%h data=%h busy=%b exp 1/4/00000aa1/1",
                     wen_ext, addr_ext, wdata_ext, busy);
        else passed++;
        start = 1'b0; n_words = 10'd3; s_data = 32'h0000_0AA2;
        @(negedge clk);
        total++;
        if ({wen_ext, addr_ext, s_ready} !== {1'b1, 64'd8, 1'b0})
            $display("FAIL ign_wr2 got wen=%b addr=%h rdy=%b exp 1/8/0", wen_ext, addr_ext, s_ready);
        else passed++;
        s_valid = 1'b0;
        wait_run(40, cyc);
        total++;
        if (cyc !== run_lat(3)) $display("FAIL ign_run_lat got=%0d exp=%0d", cyc, run_lat(3));
        else passed++;
    endtask

    task automatic test_zero();
        apply_reset();
        total++;
        if (cpu_enable !== 1'b0) $display("FAIL zero_idle got=%b exp=0", cpu_enable);
        else passed++;
        start = 1'b1; n_words = 10'd0;
        @(negedge clk);
        total++;
        if ({cpu_enable, done, wen_ext, busy} !== 4'b1100)
            $display("FAIL zero_run got=%b exp=1100", {cpu_enable, done, wen_ext, busy});
        else passed++;
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({cpu_enable, wen_ext} !== 2'b10)
            $display("FAIL zero_hold got=%b exp=10", {cpu_enable, wen_ext});
        else passed++;
    endtask

    task automatic test_reset_mid();
        int pulses;
        start = 1'b1; n_words = 10'd4; s_valid = 1'b1; s_data = 32'h0000_1000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        s_data = 32'h0000_1001;
        @(negedge clk);
        total++;
        if ({wen_ext, addr_ext} !== {1'b1, 64'd4})
            $display("FAIL rmid_wr1 got wen=%b addr=%h exp 1/4", wen_ext, addr_ext);
        else passed++;
        arst_n = 1'b0; s_data = 32'h0000_1002;
        @(negedge clk);
        total++;
        if ({cpu_enable, done, busy, err, wen_ext, ren_ext, s_ready, addr_ext, wdata_ext} !== '0)
            $display("FAIL rmid_out got flags=%b addr=%h data=%h exp all 0",
                     {cpu_enable, done, busy, err, wen_ext, ren_ext, s_ready}, addr_ext, wdata_ext);
        else passed++;
        arst_n = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (wen_ext === 1'b1 || ren_ext === 1'b1 || busy === 1'b1) pulses++;
        end
        s_valid = 1'b0;
        total++;
        if (pulses !== 0) $display("FAIL rmid_after got=%0d active cycles exp=0", pulses);
        else passed++;
    endtask

    task automatic test_saturate();
        int nw;
        int bad;
        int cyc;
        start = 1'b1; n_words = 10'h3FF; s_valid = 1'b1; s_data = '0;
        @(negedge clk);
        start = 1'b0;
        nw = 0; bad = 0; cyc = 0;
        while (cpu_enable !== 1'b1 && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            if (wen_ext === 1'b1) begin
                if (addr_ext !== 64'(4 * nw)) bad++;
                nw++;
            end
            s_data = 32'(nw + 1);
        end
        s_valid = 1'b0;
        total++;
        if (nw !== 512) $display("FAIL sat_count got=%0d exp=512", nw);
        else passed++;
        total++;
        if (bad !== 0 || cpu_enable !== 1'b1)
            $display("FAIL sat_addr got bad=%0d run=%b exp 0/1", bad, cpu_enable);
        else passed++;
    endtask

`ifdef LOADER_READBACK_EN
    task automatic test_readback();
        int cyc;
        apply_reset();
        corrupt = 1'b1;
        start = 1'b1; n_words = 10'd2; s_valid = 1'b1; s_data = 32'h0000_0010;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        s_data = 32'h0000_0001;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({ren_ext, wen_ext, addr_ext, busy} !== {1'b1, 1'b0, 64'd0, 1'b1})
            $display("FAIL rb_rd0 got ren=%b wen=%b addr=%h busy=%b exp 1/0/0/1", ren_ext, wen_ext, addr_ext, busy);
        else passed++;
        @(negedge clk);
        total++;
        if ({ren_ext, addr_ext} !== {1'b1, 64'd4})
            $display("FAIL rb_rd1 got ren=%b addr=%h exp 1/4", ren_ext, addr_ext);
        else passed++;
        @(negedge clk);
        total++;
        if (ren_ext !== 1'b0) $display("FAIL rb_rd_end got=%b exp=0", ren_ext);
        else passed++;
        @(negedge clk);
        total++;
        if ({err, cpu_enable, done} !== 3'b100)
            $display("FAIL rb_err got=%b exp=100", {err, cpu_enable, done});
        else passed++;
        @(negedge clk);
        total++;
        if (err !== 1'b1) $display("FAIL rb_err_hold got=%b exp=1", err);
        else passed++;
        corrupt = 1'b0;
        start = 1'b1; n_words = 10'd2; s_valid = 1'b1; s_data = 32'h0000_0010;
        @(negedge clk);
        total++;
        if ({err, busy} !== 2'b01) $display("FAIL rb_reload got=%b exp=01", {err, busy});
        else passed++;
        start = 1'b0;
        @(negedge clk);
        s_data = 32'h0000_0001;
        @(negedge clk);
        s_valid = 1'b0;
        wait_run(40, cyc);
        total++;
        if (cyc !== run_lat(2) || err !== 1'b0)
            $display("FAIL rb_reload_run got lat=%0d err=%b exp %0d/0", cyc, err, run_lat(2));
        else passed++;
    endtask
`endif

    initial begin
        arst_n = 1'b0; start = 1'b0; s_valid = 1'b0; n_words = '0; s_data = '0;
        test_reset();
        test_load3();
        test_toggle();
        test_start_ignored();
        test_zero();
        test_reset_mid();
        test_saturate();
`ifdef LOADER_READBACK_EN
        test_readback();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
